wrr_credit_scheduler: RTL and testbench

Credit-based weighted round-robin scheduler that shares one output path among 4 virtual-channel FIFOs. Per-channel 4-bit weights are loaded on init. The block issues one-hot pop strobes so that channel c is served up to weight[c] consecutive times per round. It sits between the virtual-channel FIFOs (empty flags in, pop strobes out) and the downstream sink (full/stall in).

---
 rtl/wrr_credit_scheduler_pkg.sv | 19 +
 rtl/wrr_credit_scheduler_if.sv | 14 +
 rtl/wrr_credit_scheduler_rr_pick.sv | 21 ++
 rtl/wrr_credit_scheduler.sv | 134 +++++++++++++
 tb/tb_wrr_credit_scheduler.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/wrr_credit_scheduler_pkg.sv
// Shared definitions for the credit-based weighted round-robin scheduler:
// channel/weight sizing, FSM state encoding and a saturating increment helper.
package wrr_credit_scheduler_pkg;

  localparam int NUM_CH   = 4;
  localparam int WEIGHT_W = 4;
  localparam int STAT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == {STAT_W{1'b1}}) ? value : value + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/wrr_credit_scheduler_if.sv
// FIFO/sink handshake bundle of the scheduler: empty/stall in, pop/grant_id/refill out.
interface wrr_credit_scheduler_if;
  import wrr_credit_scheduler_pkg::*;

  logic [NUM_CH-1:0] empty;
  logic              stall;
  logic [NUM_CH-1:0] pop;
  logic [1:0]        grant_id;
  logic              refill;

  modport master (input empty, input stall, output pop, output grant_id, output refill);
  modport slave  (output empty, output stall, input pop, input grant_id, input refill);

endinterface

// File: rtl/wrr_credit_scheduler_rr_pick.sv
// Combinational rotating-priority picker: first set bit of eligible at or after ptr (mod 4).
module wrr_rr_pick
  import wrr_credit_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] eligible,
  input  logic [1:0]        ptr,
  output logic              found,
  output logic [1:0]        win
);

  // Scan from the farthest offset down so the offset nearest ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      found = found | eligible[ptr + 2'(i)];
      win   = eligible[ptr + 2'(i)] ? (ptr + 2'(i)) : win;
    end
  end

endmodule

// File: rtl/wrr_credit_scheduler.sv
// Credit-based WRR scheduler over 4 virtual-channel FIFOs with Mealy pop strobes.
// Optional per-channel saturating grant counters are enabled with `define WRR_STATS_EN.
module wrr_credit_scheduler
  import wrr_credit_scheduler_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enb,
  input  logic                         init,
  input  logic [NUM_CH*WEIGHT_W-1:0]   weight_cfg,
  output logic                         cfg_loaded,
  output logic [NUM_CH*STAT_W-1:0]     grant_count,
  wrr_credit_scheduler_if.master       bus
);

  state_t              state_r;
  logic [1:0]          ptr_r;
  logic [WEIGHT_W-1:0] weight_r [NUM_CH];
  logic [WEIGHT_W-1:0] credit_r [NUM_CH];
  logic                cfg_loaded_r;

  logic [NUM_CH-1:0]   eligible_s;
  logic [NUM_CH-1:0]   backlog_s;
  logic                found_s;
  logic [1:0]          win_s;
  logic                run_s;
  logic                grant_s;
  logic                refill_s;
  logic [WEIGHT_W-1:0] credit_next_s;

  wrr_rr_pick u_pick (
    .eligible (eligible_s),
    .ptr      (ptr_r),
    .found    (found_s),
    .win      (win_s)
  );

  // Eligibility, grant/refill decisions; init in RUN suppresses both for that cycle.
  always_comb begin
    eligible_s = 4'b0000;
    backlog_s  = 4'b0000;
    for (int c = 0; c < NUM_CH; c++) begin
      eligible_s[c] = !bus.empty[c] && (credit_r[c] != 4'd0);
      backlog_s[c]  = !bus.empty[c] && (weight_r[c] != 4'd0);
    end
    run_s         = enb && !rst && !init && (state_r == ST_RUN) && !bus.stall;
    grant_s       = run_s && found_s;
    refill_s      = run_s && !found_s && (|backlog_s);
    credit_next_s = credit_r[win_s] - 4'd1;
  end

  assign bus.pop      = grant_s ? (4'b0001 << win_s) : 4'b0000;
  assign bus.grant_id = grant_s ? win_s : 2'd0;
  assign bus.refill   = refill_s;
  assign cfg_loaded   = cfg_loaded_r;

  // FSM, weight/credit registers and rotation pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= 2'd0;
      cfg_loaded_r <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        weight_r[c] <= 4'd0;
        credit_r[c] <= 4'd0;
      end
    end else if (enb) begin
      case (state_r)
        ST_IDLE: begin
          state_r <= init ? ST_LOAD : ST_IDLE;
        end
        ST_LOAD: begin
          for (int c = 0; c < NUM_CH; c++) begin
            weight_r[c] <= weight_cfg[WEIGHT_W*c +: WEIGHT_W];
            credit_r[c] <= weight_cfg[WEIGHT_W*c +: WEIGHT_W];
          end
          ptr_r        <= 2'd0;
          state_r      <= ST_RUN;
          cfg_loaded_r <= 1'b1;
        end
        ST_RUN: begin
          if (init) begin
            state_r      <= ST_LOAD;
            cfg_loaded_r <= 1'b0;
          end else if (grant_s) begin
            // Stay on the winner while it has credit so its burst is contiguous.
            credit_r[win_s] <= credit_next_s;
            ptr_r           <= (credit_next_s == 4'd0) ? (win_s + 2'd1) : win_s;
          end else if (refill_s) begin
            for (int c = 0; c < NUM_CH; c++) begin
              credit_r[c] <= weight_r[c];
            end
          end else begin
            ptr_r <= ptr_r;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          cfg_loaded_r <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

`ifdef WRR_STATS_EN
  logic [STAT_W-1:0] count_r [NUM_CH];

  // Per-channel grant counters; cleared on reset and on every entry to LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) count_r[c] <= 8'd0;
    end else if (enb && init && ((state_r == ST_IDLE) || (state_r == ST_RUN))) begin
      for (int c = 0; c < NUM_CH; c++) count_r[c] <= 8'd0;
    end else if (grant_s) begin
      count_r[win_s] <= sat_inc(count_r[win_s]);
    end else begin
      count_r[0] <= count_r[0];
    end
  end

  // Pack the counters onto the flat output.
  always_comb begin
    grant_count = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      grant_count[STAT_W*c +: STAT_W] = count_r[c];
    end
  end
`else
  assign grant_count = {(NUM_CH*STAT_W){1'b0}};
`endif

endmodule

// File: tb/tb_wrr_credit_scheduler.sv
// Directed self-checking bench for wrr_credit_scheduler; grant_count expectations
// follow WRR_STATS_EN (all-zero when the macro is not defined).
module tb_wrr_credit_scheduler;

  localparam logic [3:0] NP = 4'b0000;
  localparam logic [3:0] P0 = 4'b0001;
  localparam logic [3:0] P1 = 4'b0010;
  localparam logic [3:0] P2 = 4'b0100;
  localparam logic [3:0] P3 = 4'b1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic        init;
  logic [15:0] weight_cfg;
  logic        cfg_loaded;
  logic [31:0] grant_count;

  int total = 0;
  int bad   = 0;
  int exp_gc [4];

  wrr_credit_scheduler_if bus ();

  wrr_credit_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .init        (init),
    .weight_cfg  (weight_cfg),
    .cfg_loaded  (cfg_loaded),
    .grant_count (grant_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] p);
    case (p)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic clr_gc();
    for (int c = 0; c < 4; c++) exp_gc[c] = 0;
  endtask

  task automatic chk_gc(input string tag);
    logic [31:0] e;
    e = 32'd0;
`ifdef WRR_STATS_EN
    for (int c = 0; c < 4; c++) e[8*c +: 8] = 8'(exp_gc[c]);
`endif
    chk(tag, grant_count, e);
  endtask

  // One clock cycle: check combinational outputs mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic [3:0] ep, input logic er);
    #1;
    chk({tag, "_pop"}, 32'(bus.pop), 32'(ep));
    chk({tag, "_refill"}, 32'(bus.refill), 32'(er));
    chk({tag, "_gid"}, 32'(bus.grant_id), 32'(onehot_idx(ep)));
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++)
      if (ep[c] && exp_gc[c] < 255) exp_gc[c]++;
  endtask

  initial begin
    clr_gc();
    rst = 1'b1; enb = 1'b1; init = 1'b0; weight_cfg = 16'h0000;
    bus.empty = 4'hF; bus.stall = 1'b0;
    @(posedge clk); #1;
    chk("rst_cfg_loaded", 32'(cfg_loaded), 32'd0);
    chk_gc("rst_gc");
    cyc("rst_hold", NP, 1'b0);

    // Test 1: weights 3,1,2,0 with all FIFOs non-empty.
    rst = 1'b0; weight_cfg = 16'h0213; bus.empty = 4'h0; init = 1'b1;
    cyc("t1_idle", NP, 1'b0);
    clr_gc(); init = 1'b0;
    chk("t1_cfg_in_load", 32'(cfg_loaded), 32'd0);
    cyc("t1_load", NP, 1'b0);
    chk("t1_cfg_run", 32'(cfg_loaded), 32'd1);
    cyc("t1_a", P0, 1'b0); cyc("t1_b", P0, 1'b0); cyc("t1_c", P0, 1'b0);
    cyc("t1_d", P1, 1'b0); cyc("t1_e", P2, 1'b0); cyc("t1_f", P2, 1'b0);
    cyc("t1_refill", NP, 1'b1);
    cyc("t1_g", P0, 1'b0);
    chk_gc("t1_gc");

    // Test 3: stall mid-burst of ch0 (credit 2).
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t3_stall", NP, 1'b0);
    chk_gc("t3_gc_stall");
    bus.stall = 1'b0;
    cyc("t3_a", P0, 1'b0); cyc("t3_b", P0, 1'b0);
    chk_gc("t3_gc");

    // Test 2: re-init, ch0 drains after one pop and returns later with credit 2.
    init = 1'b1;
    cyc("t2_init", NP, 1'b0);
    clr_gc(); init = 1'b0;
    cyc("t2_load", NP, 1'b0);
    cyc("t2_a", P0, 1'b0);
    bus.empty = 4'b0001;
    cyc("t2_b", P1, 1'b0); cyc("t2_c", P2, 1'b0); cyc("t2_d", P2, 1'b0);
    bus.empty = 4'h0;
    cyc("t2_e", P0, 1'b0); cyc("t2_f", P0, 1'b0);
    cyc("t2_refill", NP, 1'b1);
    chk_gc("t2_gc");

    // Test 4: everything empty in RUN.
    bus.empty = 4'hF;
    for (int i = 0; i < 10; i++) cyc("t4_empty", NP, 1'b0);

    // Test 5: init in RUN with weights 1,1,1,1 while ch1 would otherwise be popped.
    bus.empty = 4'h0; weight_cfg = 16'h1111; init = 1'b1;
    cyc("t5_init", NP, 1'b0);
    clr_gc(); init = 1'b0;
    chk("t5_cfg_in_load", 32'(cfg_loaded), 32'd0);
    cyc("t5_load", NP, 1'b0);
    chk_gc("t5_gc_clear");
    cyc("t5_a", P0, 1'b0); cyc("t5_b", P1, 1'b0); cyc("t5_c", P2, 1'b0);
    cyc("t5_d", P3, 1'b0); cyc("t5_refill", NP, 1'b1); cyc("t5_e", P0, 1'b0);

    // Test 4b: all weights zero, all FIFOs non-empty.
    weight_cfg = 16'h0000; init = 1'b1;
    cyc("t4b_init", NP, 1'b0);
    clr_gc(); init = 1'b0;
    cyc("t4b_load", NP, 1'b0);
    for (int i = 0; i < 4; i++) cyc("t4b_zero", NP, 1'b0);

    // Test 6: enb freeze then reset mid-burst.
    weight_cfg = 16'h0213; init = 1'b1;
    cyc("t6_init", NP, 1'b0);
    clr_gc(); init = 1'b0;
    cyc("t6_load", NP, 1'b0);
    cyc("t6_a", P0, 1'b0); cyc("t6_b", P0, 1'b0);
    enb = 1'b0;
    cyc("t6_enb0", NP, 1'b0); cyc("t6_enb1", NP, 1'b0);
    enb = 1'b1;
    cyc("t6_c", P0, 1'b0); cyc("t6_d", P1, 1'b0);
    chk_gc("t6_gc");
    rst = 1'b1;
    cyc("t6_rst", NP, 1'b0);
    clr_gc(); rst = 1'b0;
    chk("t6_cfg_after_rst", 32'(cfg_loaded), 32'd0);
    chk_gc("t6_gc_rst");
    for (int i = 0; i < 3; i++) cyc("t6_noinit", NP, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
